// File: rtl/alu8_op_sequencer.sv
// Command-driven sequencer for the 8-bit ALU datapath, with a shift-add multiplier.
// It accepts one operation at a time and holds the result and flags until the consumer takes it.
module alu8_op_sequencer #(
  parameter int WIDTH      = 8,
  parameter int MUL_CYCLES = WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [2:0]         cmd_op,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [2*WIDTH-1:0] out,
  output logic               flag_zero,
  output logic               flag_carry,
  output logic               busy
);

  localparam int CW = $clog2(MUL_CYCLES + 1);
  localparam logic [CW-1:0] LAST_ITER = CW'(MUL_CYCLES - 1);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_NOT  = 3'b101;
  localparam logic [2:0] OP_MUL  = 3'b110;
  localparam logic [2:0] OP_PASS = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MUL  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t               state_r, state_s;
  logic [2:0]           op_r;
  logic [WIDTH-1:0]     a_r, b_r;
  logic [2*WIDTH-1:0]   acc_r, acc_s, mcand_r;
  logic [WIDTH-1:0]     mplier_r;
  logic [CW-1:0]        cnt_r;
  logic [2*WIDTH-1:0]   out_r;
  logic                 zero_r, carry_r;
  logic                 cmd_ready_r, res_valid_r, busy_r;
  logic [2*WIDTH:0]     alu_s;

  // Single-cycle ALU result; bit 2*WIDTH carries the ADD carry-out or SUB borrow.
  function automatic logic [2*WIDTH:0] alu_f(input logic [2:0] op,
                                             input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
    logic [WIDTH:0]   wide;
    logic [WIDTH-1:0] r;
    logic             c;
    wide = {(WIDTH+1){1'b0}};
    r    = {WIDTH{1'b0}};
    c    = 1'b0;
    case (op)
      OP_ADD: begin
        wide = {1'b0, a} + {1'b0, b};
        r    = wide[WIDTH-1:0];
        c    = wide[WIDTH];
      end
      OP_SUB: begin
        wide = {1'b0, a} - {1'b0, b};
        r    = wide[WIDTH-1:0];
        c    = wide[WIDTH];
      end
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NOT:  r = ~a;
      OP_PASS: r = b;
      default: r = {WIDTH{1'b0}};
    endcase
    return {c, {WIDTH{1'b0}}, r};
  endfunction

  assign alu_s = alu_f(op_r, a_r, b_r);

  // Multiplier partial sum: the multiplicand is pre-shifted, so it is added as-is.
  always_comb begin
    acc_s = acc_r;
    if (mplier_r[0]) begin
      acc_s = acc_r + mcand_r;
    end else begin
      acc_s = acc_r;
    end
  end

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (cmd_valid) begin
          state_s = (cmd_op == OP_MUL) ? ST_MUL : ST_EXEC;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_EXEC: state_s = ST_DONE;
      ST_MUL: begin
        if (cnt_r == LAST_ITER) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_MUL;
        end
      end
      ST_DONE: begin
        if (res_ready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Handshake and status outputs, registered from the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cmd_ready_r <= 1'b1;
      res_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      cmd_ready_r <= (state_s == ST_IDLE);
      res_valid_r <= (state_s == ST_DONE);
      busy_r      <= (state_s == ST_EXEC) || (state_s == ST_MUL);
    end
  end

  // Operand capture, multiplier iteration and result/flag registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_r     <= 3'b000;
      a_r      <= {WIDTH{1'b0}};
      b_r      <= {WIDTH{1'b0}};
      acc_r    <= {(2*WIDTH){1'b0}};
      mcand_r  <= {(2*WIDTH){1'b0}};
      mplier_r <= {WIDTH{1'b0}};
      cnt_r    <= {CW{1'b0}};
      out_r    <= {(2*WIDTH){1'b0}};
      zero_r   <= 1'b0;
      carry_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (cmd_valid) begin
            op_r     <= cmd_op;
            a_r      <= in_a;
            b_r      <= in_b;
            acc_r    <= {(2*WIDTH){1'b0}};
            mcand_r  <= {{WIDTH{1'b0}}, in_a};
            mplier_r <= in_b;
            cnt_r    <= {CW{1'b0}};
          end
        end
        ST_EXEC: begin
          out_r   <= alu_s[2*WIDTH-1:0];
          zero_r  <= (alu_s[2*WIDTH-1:0] == {(2*WIDTH){1'b0}});
          carry_r <= alu_s[2*WIDTH];
        end
        ST_MUL: begin
          acc_r    <= acc_s;
          mcand_r  <= mcand_r << 1;
          mplier_r <= mplier_r >> 1;
          cnt_r    <= cnt_r + CW'(1);
          // The last iteration's sum goes straight to the output, saving a cycle.
          if (cnt_r == LAST_ITER) begin
            out_r   <= acc_s;
            zero_r  <= (acc_s == {(2*WIDTH){1'b0}});
            carry_r <= 1'b0;
          end
        end
        ST_DONE: begin
          out_r <= out_r;
        end
        default: begin
          out_r <= out_r;
        end
      endcase
    end
  end

  assign cmd_ready  = cmd_ready_r;
  assign res_valid  = res_valid_r;
  assign busy       = busy_r;
  assign out        = out_r;
  assign flag_zero  = zero_r;
  assign flag_carry = carry_r;

endmodule

// File: tb/tb_alu8_op_sequencer.sv
// Directed bench for alu8_op_sequencer. A scoreboard queue holds the expected results,
// and each result is checked with an immediate assertion.
module tb_alu8_op_sequencer;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] out;
  logic        flag_zero;
  logic        flag_carry;
  logic        busy;

  int checks;
  int failures;

  typedef struct {
    logic [15:0] res;
    logic        z;
    logic        c;
    int          lat;
  } exp_t;

  exp_t sb_q[$];

  alu8_op_sequencer #(.WIDTH(8), .MUL_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .in_a(in_a), .in_b(in_b), .res_valid(res_valid),
    .res_ready(res_ready), .out(out), .flag_zero(flag_zero),
    .flag_carry(flag_carry), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model of the sequencer's result.
  function automatic exp_t model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    int   v;
    e.c   = 1'b0;
    e.lat = 2;
    v     = 0;
    case (op)
      3'd0: begin v = int'(a) + int'(b); e.c = (v > 255); v = v % 256; end
      3'd1: begin e.c = (a < b); v = (int'(a) - int'(b) + 256) % 256; end
      3'd2: v = int'(a & b);
      3'd3: v = int'(a | b);
      3'd4: v = int'(a ^ b);
      3'd5: v = 255 - int'(a);
      3'd6: begin v = int'(a) * int'(b); e.lat = 9; end
      default: v = int'(b);
    endcase
    e.res = v[15:0];
    e.z   = (v == 0);
    return e;
  endfunction

  // Present a command, wait for it to be accepted, then scramble the inputs.
  task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    int w;
    cmd_valid = 1'b1;
    cmd_op    = op;
    in_a      = a;
    in_b      = b;
    w = 0;
    while (cmd_ready !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("accept_timeout", {31'd0, cmd_ready}, 32'd1);
    sb_q.push_back(model(op, a, b));
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op    = ~op;
    in_a      = ~a;
    in_b      = ~b;
  endtask

  // Wait for res_valid, count latency and busy cycles, then compare with the scoreboard.
  task automatic collect(input string tag);
    exp_t e;
    int   lat;
    int   busy_n;
    lat    = 1;
    busy_n = 0;
    while (res_valid !== 1'b1 && lat < 40) begin
      if (busy === 1'b1) busy_n++;
      @(negedge clk);
      lat++;
    end
    check({tag, "_sb"}, {31'd0, (sb_q.size() != 0)}, 32'd1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check({tag, "_lat"}, lat, e.lat);
      check({tag, "_busy"}, busy_n, e.lat - 1);
      check({tag, "_out"}, {16'd0, out}, {16'd0, e.res});
      check({tag, "_zero"}, {31'd0, flag_zero}, {31'd0, e.z});
      check({tag, "_carry"}, {31'd0, flag_carry}, {31'd0, e.c});
    end else begin
      check({tag, "_empty"}, 32'd0, 32'd1);
    end
  endtask

  // Take the held result and confirm the handshake returns the sequencer to idle.
  task automatic consume(input string tag);
    res_ready = 1'b1;
    @(negedge clk);
    check({tag, "_drop"}, {30'd0, res_valid, cmd_ready}, 32'd1);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 3'd0;
    in_a      = 8'h00;
    in_b      = 8'h00;
    res_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    check("rst_x", {31'd0, $isunknown({cmd_ready, res_valid, out, flag_zero, flag_carry, busy})}, 32'd0);
    check("rst_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_valid", {31'd0, res_valid}, 32'd0);
    check("rst_out", {16'd0, out}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_flags", {30'd0, flag_zero, flag_carry}, 32'd0);

    send(3'd4, 8'hA5, 8'h0F); collect("xor");     consume("xor");
    send(3'd0, 8'hFF, 8'h01); collect("add_ovf"); consume("add_ovf");
    send(3'd1, 8'h00, 8'h01); collect("sub_brw"); consume("sub_brw");
    send(3'd1, 8'h05, 8'h05); collect("sub_eq");  consume("sub_eq");
    send(3'd6, 8'hFF, 8'hFF); collect("mul_ff");  consume("mul_ff");
    send(3'd6, 8'h37, 8'h00); collect("mul_0");   consume("mul_0");
    send(3'd2, 8'hF0, 8'h3C); collect("and");     consume("and");
    send(3'd5, 8'h5A, 8'h00); collect("not");     consume("not");
    send(3'd7, 8'h12, 8'h81); collect("pass");    consume("pass");

    // Backpressure: hold the OR result while a second command waits.
    res_ready = 1'b0;
    send(3'd3, 8'h30, 8'h03);
    collect("or");
    cmd_valid = 1'b1;
    cmd_op    = 3'd0;
    in_a      = 8'h01;
    in_b      = 8'h02;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_out", {16'd0, out}, 32'h0033);
      check("bp_hold", {30'd0, res_valid, cmd_ready}, 32'd2);
    end
    res_ready = 1'b1;
    @(negedge clk);
    check("bp_release", {30'd0, res_valid, cmd_ready}, 32'd1);
    send(3'd0, 8'h01, 8'h02);
    collect("bp_add");
    consume("bp_add");

    // Reset in the middle of a multiply aborts it.
    send(3'd6, 8'h0F, 8'h0B);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    if (sb_q.size() != 0) void'(sb_q.pop_back());
    check("mrst_valid", {31'd0, res_valid}, 32'd0);
    check("mrst_out", {16'd0, out}, 32'd0);
    check("mrst_idle", {30'd0, cmd_ready, busy}, 32'd2);
    send(3'd0, 8'h10, 8'h20); collect("mrst_add"); consume("mrst_add");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
